// File: rtl/regfile_sb.sv
`timescale 1ns/1ps
// Integer register file with per-register busy scoreboard; optional write-first bypass under REGFILE_BYPASS_EN.
// Latency: reads combinational, writes and scoreboard updates visible after one edge.
// Backpressure: none; every writeback and issue strobe is accepted on the cycle it is presented.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wEn,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] write_data,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] read_data1,
  output logic [XLEN-1:0] read_data2,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic [AW:0]     busy_cnt
);

  localparam int NREGS = 2**AW;

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [AW:0]      cnt_q;
  logic [AW:0]      cnt_nxt;
  logic             set_ok;
  logic             inc;
  logic             dec;

  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Set wins over clear on the same register, so the count only moves on real 0<->1 transitions.
  always_comb begin
    set_ok   = iss_en && !is_zero(iss_rd);
    inc      = set_ok && !busy[iss_rd];
    dec      = wEn && busy[rd] && !(set_ok && (iss_rd == rd));
    busy_nxt = busy;
    if (wEn)
      busy_nxt[rd] = 1'b0;
    if (set_ok)
      busy_nxt[iss_rd] = 1'b1;
    cnt_nxt = cnt_q + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (wEn && !is_zero(rd)) begin
      regs[rd] <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= '0;
      cnt_q <= '0;
    end else begin
      busy  <= busy_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  assign busy_cnt = cnt_q;

  always_comb begin
    read_data1 = regs[rs1];
    read_data2 = regs[rs2];
    rs1_busy   = busy[rs1];
    rs2_busy   = busy[rs2];
`ifdef REGFILE_BYPASS_EN
    // Write-first: an in-flight writeback retires the hazard unless a new producer claims it now.
    if (wEn && !is_zero(rd) && (rd == rs1)) begin
      read_data1 = write_data;
      rs1_busy   = iss_en && (iss_rd == rs1);
    end
    if (wEn && !is_zero(rd) && (rd == rs2)) begin
      read_data2 = write_data;
      rs2_busy   = iss_en && (iss_rd == rs2);
    end
`endif
    if (is_zero(rs1)) begin
      read_data1 = '0;
      rs1_busy   = 1'b0;
    end
    if (is_zero(rs2)) begin
      read_data2 = '0;
      rs2_busy   = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
`timescale 1ns/1ps
// Self-checking bench for regfile_sb: directed plan steps, then random traffic against an array-based model.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst, wEn, iss_en;
  logic [4:0]  rd, rs1, rs2, iss_rd;
  logic [31:0] write_data, read_data1, read_data2;
  logic        rs1_busy, rs2_busy;
  logic [5:0]  busy_cnt;

  int tests = 0;
  int fails = 0;

  logic [31:0] mreg [32];
  bit          mbusy [32];

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(32), .AW(5), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .wEn(wEn), .rd(rd), .write_data(write_data),
    .rs1(rs1), .rs2(rs2), .read_data1(read_data1), .read_data2(read_data2),
    .iss_en(iss_en), .iss_rd(iss_rd), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .busy_cnt(busy_cnt)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit bypass_hit(input logic [4:0] a);
`ifdef REGFILE_BYPASS_EN
    return wEn && (rd == a) && (rd != 5'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (bypass_hit(a)) return write_data;
    return mreg[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    if (bypass_hit(a)) return iss_en && (iss_rd == a);
    return mbusy[a];
  endfunction

  function automatic int model_cnt();
    int n = 0;
    for (int i = 0; i < 32; i++) n += mbusy[i];
    return n;
  endfunction

  task automatic drive(input bit r, input bit we, input logic [4:0] wrd, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2, input bit ie, input logic [4:0] ird);
    rst = r; wEn = we; rd = wrd; write_data = wd;
    rs1 = a1; rs2 = a2; iss_en = ie; iss_rd = ird;
  endtask

  task automatic model_check();
    check("rd1", read_data1, exp_data(rs1));
    check("rd2", read_data2, exp_data(rs2));
    check("busy1", {31'd0, rs1_busy}, {31'd0, exp_busy(rs1)});
    check("busy2", {31'd0, rs2_busy}, {31'd0, exp_busy(rs2)});
    check("cnt", {26'd0, busy_cnt}, model_cnt());
  endtask

  // Clock edge plus the architectural effect of the cycle's inputs on the model.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin mreg[i] = 32'd0; mbusy[i] = 1'b0; end
    end else begin
      if (wEn && rd != 5'd0) mreg[rd] = write_data;
      if (wEn) mbusy[rd] = 1'b0;
      if (iss_en && iss_rd != 5'd0) mbusy[iss_rd] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic step(input bit r, input bit we, input logic [4:0] wrd, input logic [31:0] wd,
                      input logic [4:0] a1, input logic [4:0] a2, input bit ie, input logic [4:0] ird);
    drive(r, we, wrd, wd, a1, a2, ie, ird);
    #1;
    model_check();
    tick();
  endtask

  task automatic look(input logic [4:0] a1, input logic [4:0] a2);
    drive(1'b0, 1'b0, 5'd0, 32'd0, a1, a2, 1'b0, 5'd0);
    #1;
  endtask

  initial begin
    logic [31:0] v;
    drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0);
    @(negedge clk);
    tick();

    // Writes before a reset must vanish.
    step(0, 1, 5'd4, 32'hA5A5A5A5, 5'd4, 5'd0, 1, 5'd8);
    step(0, 1, 5'd20, 32'h0BADF00D, 5'd4, 5'd20, 1, 5'd21);
    step(1, 0, 5'd0, 32'd0, 5'd4, 5'd20, 0, 5'd0);
    for (int i = 1; i < 32; i++) begin
      look(i[4:0], i[4:0]);
      check("rst_rd1", read_data1, 32'd0);
      check("rst_rd2", read_data2, 32'd0);
    end
    check("rst_cnt", {26'd0, busy_cnt}, 32'd0);
    check("rst_busy", {31'd0, rs1_busy}, 32'd0);

    for (int i = 1; i < 32; i++) begin
      v = i * 32'h11111111;
      step(0, 1, i[4:0], v, 5'd0, 5'd0, 0, 5'd0);
    end
    for (int i = 1; i < 32; i++) begin
      look(i[4:0], 5'(32 - i));
      v = i * 32'h11111111;
      check("sweep_rd1", read_data1, v);
      v = (32 - i) * 32'h11111111;
      check("sweep_rd2", read_data2, v);
    end
    step(0, 1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd0, 0, 5'd0);
    look(5'd0, 5'd0);
    check("x0_zero", read_data1, 32'd0);

    step(0, 0, 5'd0, 32'd0, 5'd5, 5'd7, 1, 5'd5);
    step(0, 0, 5'd0, 32'd0, 5'd5, 5'd7, 1, 5'd7);
    look(5'd5, 5'd7);
    check("sb_cnt2", {26'd0, busy_cnt}, 32'd2);
    check("sb_x5_busy", {31'd0, rs1_busy}, 32'd1);
    step(0, 1, 5'd5, 32'h1234, 5'd5, 5'd7, 0, 5'd0);
    look(5'd5, 5'd7);
    check("sb_cnt1", {26'd0, busy_cnt}, 32'd1);
    check("sb_x5_free", {31'd0, rs1_busy}, 32'd0);
    check("sb_x5_val", read_data1, 32'h1234);

    step(0, 0, 5'd0, 32'd0, 5'd9, 5'd0, 1, 5'd9);
    step(0, 1, 5'd9, 32'h99, 5'd9, 5'd0, 1, 5'd9);
    look(5'd9, 5'd3);
    check("same_x9_busy", {31'd0, rs1_busy}, 32'd1);
    check("same_cnt", {26'd0, busy_cnt}, 32'd2);
    step(0, 1, 5'd9, 32'h9A, 5'd3, 5'd9, 1, 5'd3);
    look(5'd3, 5'd9);
    check("diff_cnt", {26'd0, busy_cnt}, 32'd2);
    check("diff_x3_busy", {31'd0, rs1_busy}, 32'd1);
    check("diff_x9_free", {31'd0, rs2_busy}, 32'd0);

    drive(0, 1, 5'd6, 32'hCAFEF00D, 5'd6, 5'd0, 0, 5'd0);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_same_cycle", read_data1, 32'hCAFEF00D);
`else
    check("byp_same_cycle", read_data1, 32'h66666666);
`endif
    check("byp_busy", {31'd0, rs1_busy}, 32'd0);
    tick();
    look(5'd6, 5'd0);
    check("byp_next_cycle", read_data1, 32'hCAFEF00D);

    step(0, 0, 5'd0, 32'd0, 5'd10, 5'd11, 1, 5'd10);
    step(0, 0, 5'd0, 32'd0, 5'd10, 5'd11, 1, 5'd11);
    look(5'd10, 5'd11);
    check("pre_rst_cnt4", {26'd0, busy_cnt}, 32'd4);
    step(1, 1, 5'd12, 32'h55, 5'd12, 5'd13, 1, 5'd13);
    look(5'd12, 5'd13);
    check("mid_rst_rd", read_data1, 32'd0);
    check("mid_rst_cnt", {26'd0, busy_cnt}, 32'd0);
    check("mid_rst_busy", {31'd0, rs2_busy}, 32'd0);

    // Narrow address range on half the steps to provoke same-register collisions.
    for (int n = 0; n < 600; n++) begin
      logic [4:0] m;
      m = (n % 2 == 0) ? 5'd3 : 5'd31;
      step(($urandom_range(0, 79) == 0), $urandom_range(0, 1), 5'($urandom) & m, $urandom,
           5'($urandom) & m, 5'($urandom) & m, $urandom_range(0, 1), 5'($urandom) & m);
    end
    look(5'd1, 5'd2);
    model_check();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the CPU integer register file: 2 combinational read ports, 1 synchronous write port, with configurable width and depth.
- Adds a per-register scoreboard. A busy bit is set when an instruction issues with that rd and cleared on its writeback. The decode stage uses it for RAW hazard detection.
- Keeps an outstanding-producer counter and an optional write-to-read bypass.
- Sits between decode/issue (read + claim) and writeback (write + release).

Parameters:
- XLEN, 32, data width of each register.
- AW, 5, register address width; NREGS = 2**AW.
- ZERO_REG, 1, when 1 register 0 is hardwired to zero, never written and never busy.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- wEn  in  1  writeback enable.
- rd  in  AW  writeback destination.
- write_data  in  XLEN  writeback data.
- rs1  in  AW  read address, port 1.
- rs2  in  AW  read address, port 2.
- read_data1  out  XLEN  combinational read data, port 1.
- read_data2  out  XLEN  combinational read data, port 2.
- iss_en  in  1  issue strobe: claim iss_rd as pending.
- iss_rd  in  AW  destination being claimed.
- rs1_busy  out  1  rs1 has an outstanding producer.
- rs2_busy  out  1  rs2 has an outstanding producer.
- busy_cnt  out  AW+1  number of busy registers.

Behaviour:
- Reset (synchronous, active-high): at the clock edge where rst=1, all NREGS registers clear to 0, all busy bits clear, busy_cnt=0. wEn and iss_en are ignored that cycle. From the following cycle, read_data1/2=0 for any address, rs1_busy=rs2_busy=0, busy_cnt=0. Reset mid-operation discards all pending claims.
- Write: if wEn=1 and !(ZERO_REG && rd==0), reg[rd] <= write_data on the edge (write latency 1).
- Read: read_data_n = reg[rs_n] combinationally. Address 0 reads 0 when ZERO_REG=1. Reads have no latency.
- Scoreboard set/clear:
  - set: iss_en=1 and iss_rd not the zero register sets busy[iss_rd].
  - clear: wEn=1 clears busy[rd].
  - Different registers in the same cycle: both take effect.
  - Same register, both events in one cycle: set wins, so the register stays busy for the new producer and busy_cnt is unchanged.
  - Set on an already-busy register: no change to busy, no change to busy_cnt (WAW is an issue-stage concern, not an error here).
  - Writeback to a non-busy register: data is written, busy stays 0, busy_cnt unchanged.
- busy_cnt: registered; equals popcount(busy) after every edge.
  - Per cycle it changes by +1, -1, 0 or 0 as netted from the set/clear rules above.
  - It never wraps, because busy bits are unique; max value is NREGS-ZERO_REG.
- rsN_busy = busy[rsN] from registered state, subject to the bypass rule below. Always 0 for the zero register when ZERO_REG=1.
- No state machine beyond reset/run. All outputs are driven by clean flops or by combinational decode of them.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined, data: if wEn=1, rd==rs_n and rd is not the zero register, read_data_n = write_data in the same cycle (write-first).
- Defined, busy: in that case rs_n_busy is forced to 0, unless iss_en=1 && iss_rd==rs_n in the same cycle, in which case it reads 1.
- Undefined: reads return the stored value, so a write becomes visible one cycle after wEn. rs_n_busy reflects registered busy bits only; the clear becomes visible one cycle after writeback.

Test Plan:
- Reset: assert rst for 1 edge after prior writes -> next cycle read_data1/2=0 for x1..x31, busy_cnt=0, rs1_busy=0.
- Write/read sweep: write xi = i*32'h11111111 for i=1..31, then read rs1=i and rs2=32-i -> both ports match expected. Write x0=32'hDEADBEEF -> x0 reads 0.
- Scoreboard: issue x5, then x7 -> busy_cnt=2, rs1=5 busy=1. Write x5=32'h1234 -> next cycle busy_cnt=1, rs1_busy=0, read_data1=32'h1234.
- Simultaneous set+clear on x9 while busy -> x9 stays busy, busy_cnt unchanged. Set x3 with clear x9 in the same cycle -> busy_cnt unchanged, x3 busy, x9 free.
- Bypass, REGFILE_BYPASS_EN defined: wEn=1, rd=rs1=6, write_data=32'hCAFEF00D -> read_data1=32'hCAFEF00D and rs1_busy=0 in the same cycle. Undefined: old value in the same cycle, new value one cycle later.
- Reset while busy_cnt=4 with wEn and iss_en both asserted -> all busy cleared, busy_cnt=0, written register reads 0.
